dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Wait-state data-memory target: the responding end of the CPU data-memory interface (`memwrite`, `dataadr`, `writedata`, `readdata`), extended with a request/ready handshake.
- Holds a word-addressed storage array and answers each CPU request after a programmable number of wait states.
- Flags misaligned or out-of-range accesses.
- Sits between the cpu and the main-memory data segment in the computer top level, for multi-cycle memory experiments.

Parameters:
- n, 32, data/address width in bits
- DEPTH, 64, number of n-bit words stored; word index = dataadr[(n-1):2]
- LATENCY, 2, clock edges from acceptance to response; legal range 1..15

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req  input  1  CPU request valid; held high until ready
- memwrite  input  1  1 = write, 0 = read; sampled with req
- dataadr  input  n  byte address; sampled with req
- writedata  input  n  write data; sampled with req
- readdata  output  n  registered read data
- ready  output  1  one-cycle response strobe
- err  output  1  error flag, valid while ready=1

Behaviour:
- Reset: reset=0 asynchronously forces
  - state=IDLE, ready=0, err=0, readdata=0, wait counter=0
  - storage array is not reset; it keeps its contents
  - reset mid-transaction aborts the transaction: no write is committed and no ready is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with req=1: capture memwrite, dataadr and writedata into internal registers.
  - Load cnt=LATENCY-1 and go to WAIT. This edge is the acceptance edge E0.
  - With req=0: stay in IDLE.
- WAIT:
  - Captured values are used; live inputs are ignored.
  - Each edge: if cnt==0, go to RESP; otherwise cnt<=cnt-1.
- Actions on the edge entering RESP (edge E0+LATENCY):
  - Bad access = dataadr[1:0]!=0 or word index>=DEPTH. On a bad access: err<=1, no array write, readdata<=0.
  - Good write: array[idx]<=writedata, err<=0, readdata unchanged.
  - Good read: readdata<=array[idx], err<=0.
- RESP:
  - ready=1 for exactly this one cycle; next edge returns to IDLE.
  - A new request cannot be accepted before the edge following RESP.
  - Minimum issue-to-issue spacing is LATENCY+2 edges.
- ready and err are registered outputs. err returns to 0 on the edge leaving RESP.
- readdata holds its last value until the next good read (or a bad access, which sets it to 0).
- req dropping during WAIT is a protocol violation. The transaction still completes; no check is made.
- LATENCY outside 1..15 is a compile-time error (elaboration assertion).

Optional Feature:
- Macro: DMEM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed from writedata on commit.
  - On a good read, if stored parity != XOR of the stored data, err<=1 and readdata<=stored data (the data is still returned).
- Undefined:
  - No parity storage.
  - err is raised only for misaligned or out-of-range accesses.

Decomposition:
- Package dmem_resp_pkg holds:
  - state enum typedef (IDLE, WAIT, RESP)
  - constants LATENCY_MIN=1, LATENCY_MAX=15
  - counter width 4
  - ERR_READDATA=0
- One sub-module: wait_counter. Loadable 4-bit down-counter with load, load value, and zero flag. It is instantiated once for the WAIT timing.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then req=0 for 10 cycles -> ready=0, err=0, readdata=0 throughout.
- Write then read, LATENCY=2:
  - req with memwrite=1, dataadr=0x10, writedata=0xCAFE_F00D -> ready high exactly 2 edges after acceptance, err=0.
  - Then a read of 0x10 -> readdata=0xCAFE_F00D with ready, again 2 edges after acceptance.
- Error accesses:
  - Read of dataadr=0x13 (misaligned) -> err=1, readdata=0.
  - Write of 0x100 (index 64 >= DEPTH) -> err=1; a following read of 0x0 shows location 0 unchanged.
- LATENCY=1 and LATENCY=15 builds: for a read of 0x4, ready asserts 1 and 15 edges after acceptance respectively. ready width is always one cycle.
- Reset mid-operation: write 0x20<=0x1234_5678 with reset pulsed low during WAIT -> no ready; a subsequent read of 0x20 returns the prior contents (preloaded 0xAAAA_AAAA).
- DMEM_PARITY_EN build: write 0x8<=0x0000_0001, force-flip bit 0 of that array word, read 0x8 -> err=1, readdata=0x0000_0000.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
// Optional parity protection is enabled in dmem_responder with DMEM_PARITY_EN.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int LATENCY_MIN  = 1;
    localparam int LATENCY_MAX  = 15;
    localparam int CNT_W        = 4;
    localparam int ERR_READDATA = 0;

endpackage

// File: rtl/dmem_responder_wait_counter.sv
// Loadable down-counter that times the wait states between acceptance and response.
// It holds at zero rather than wrapping, so the zero flag stays valid while the FSM reacts.
import dmem_resp_pkg::*;

module wait_counter (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory target: answers each CPU request LATENCY edges after acceptance.
// Define DMEM_PARITY_EN to store an even-parity bit per word and flag corrupted reads.
import dmem_resp_pkg::*;

module dmem_responder #(
    parameter int n       = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         memwrite,
    input  logic [n-1:0] dataadr,
    input  logic [n-1:0] writedata,
    output logic [n-1:0] readdata,
    output logic         ready,
    output logic         err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_RESP = RESP;

    if ((LATENCY < LATENCY_MIN) || (LATENCY > LATENCY_MAX)) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be within 1..15");
    end

    logic [1:0]    state;
    logic          we_q;
    logic [n-1:0]  adr_q;
    logic [n-1:0]  wdata_q;
    logic          cnt_zero;
    logic          bad;
    logic          finishing;
    logic          commit_write;
    logic [AW-1:0] idx;

    logic [n-1:0]  mem [DEPTH];
`ifdef DMEM_PARITY_EN
    logic          par_mem [DEPTH];
`endif

    wait_counter u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       ((state == S_IDLE) && req),
        .en         (state == S_WAIT),
        .load_value (CNT_W'(LATENCY - 1)),
        .zero       (cnt_zero)
    );

    assign idx          = adr_q[AW+1:2];
    assign bad          = (adr_q[1:0] != 2'b00) || (adr_q[n-1:2] >= (n-2)'(DEPTH));
    assign finishing    = (state == S_WAIT) && cnt_zero;
    assign commit_write = finishing && we_q && !bad;

    // Storage has no reset; an async reset forces state to IDLE, which blocks any pending commit.
    always_ff @(posedge clk) begin
        if (commit_write) begin
            mem[idx] <= wdata_q;
`ifdef DMEM_PARITY_EN
            par_mem[idx] <= ^wdata_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ready    <= 1'b0;
            err      <= 1'b0;
            readdata <= '0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wdata_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    if (req) begin
                        we_q    <= memwrite;
                        adr_q   <= dataadr;
                        wdata_q <= writedata;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_zero) begin
                        state <= S_RESP;
                        ready <= 1'b1;
                        if (bad) begin
                            err      <= 1'b1;
                            readdata <= n'(ERR_READDATA);
                        end else if (!we_q) begin
                            readdata <= mem[idx];
`ifdef DMEM_PARITY_EN
                            err      <= (par_mem[idx] != ^mem[idx]);
`else
                            err      <= 1'b0;
`endif
                        end else begin
                            err <= 1'b0;
                        end
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table plus reset and latency corner cases.
// Three instances cover LATENCY = 2, 1 and 15; the parity case runs when DMEM_PARITY_EN is defined.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req2, req1, req15;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] rd2, rd1, rd15;
    logic        rdy2, rdy1, rdy15;
    logic        err2, err1, err15;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.n(32), .DEPTH(64), .LATENCY(2)) dut_l2 (
        .clk(clk), .reset(reset), .req(req2), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .readdata(rd2), .ready(rdy2), .err(err2)
    );

    dmem_responder #(.n(32), .DEPTH(64), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .req(req1), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .readdata(rd1), .ready(rdy1), .err(err1)
    );

    dmem_responder #(.n(32), .DEPTH(64), .LATENCY(15)) dut_l15 (
        .clk(clk), .reset(reset), .req(req15), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .readdata(rd15), .ready(rdy15), .err(err15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    function automatic logic get_rdy(input int sel);
        case (sel)
            1:       return rdy1;
            15:      return rdy15;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic get_err(input int sel);
        case (sel)
            1:       return err1;
            15:      return err15;
            default: return err2;
        endcase
    endfunction

    function automatic logic [31:0] get_rd(input int sel);
        case (sel)
            1:       return rd1;
            15:      return rd15;
            default: return rd2;
        endcase
    endfunction

    task automatic set_req(input int sel, input logic v);
        case (sel)
            1:       req1 = v;
            15:      req15 = v;
            default: req2 = v;
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One transaction: acceptance on the first rising edge, then count edges until ready.
    task automatic applyStimulus(input int sel, input logic we, input logic [31:0] adr,
                                 input logic [31:0] wd, output int lat, output logic got_err,
                                 output logic [31:0] got_rd, output logic width_ok);
        @(negedge clk);
        memwrite  = we;
        dataadr   = adr;
        writedata = wd;
        set_req(sel, 1'b1);
        @(posedge clk);
        lat     = 0;
        got_err = 1'bx;
        got_rd  = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (get_rdy(sel)) begin
                lat = k;
                break;
            end
        end
        got_err = get_err(sel);
        got_rd  = get_rd(sel);
        set_req(sel, 1'b0);
        @(posedge clk);
        #1;
        width_ok = !get_rdy(sel);
    endtask

    task automatic run_checked(input string tag, input int sel, input logic we,
                               input logic [31:0] adr, input logic [31:0] wd,
                               input logic [31:0] exp_rd, input logic exp_err);
        int          lat;
        logic        e;
        logic [31:0] r;
        logic        w;
        applyStimulus(sel, we, adr, wd, lat, e, r, w);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(sel));
        checkOutput({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
        checkOutput({tag, "_readdata"}, r, exp_rd);
        checkOutput({tag, "_ready_width"}, {31'b0, w}, 32'd1);
    endtask

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h1111_2222, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[4]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h1111_2222, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_00FC, 32'h5555_AAAA, 32'h1111_2222, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 32'h5555_AAAA, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0020, 32'hAAAA_AAAA, 32'h5555_AAAA, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_0104, 32'h0000_0000, 32'h0000_0000, 1'b1};

        reset     = 1'b0;
        req2      = 1'b0;
        req1      = 1'b0;
        req15     = 1'b0;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", {31'b0, rdy2}, 32'd0);
        checkOutput("reset_err", {31'b0, err2}, 32'd0);
        checkOutput("reset_readdata", rd2, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("idle%0d_outputs", c), {rd2[29:0], rdy2, err2}, 32'd0);
        end

        for (int i = 0; i < 11; i++) begin
            run_checked($sformatf("v%0d", i), 2, vecs[i].we, vecs[i].adr, vecs[i].wd,
                        vecs[i].exp_rd, vecs[i].exp_err);
        end

        // Reset pulsed during WAIT must abort the write and suppress ready.
        @(negedge clk);
        memwrite  = 1'b1;
        dataadr   = 32'h0000_0020;
        writedata = 32'h1234_5678;
        req2      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        req2  = 1'b0;
        #1;
        checkOutput("midreset_ready", {31'b0, rdy2}, 32'd0);
        checkOutput("midreset_readdata", rd2, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1;
                if (rdy2) seen = 1'b1;
            end
            checkOutput("midreset_no_ready", {31'b0, seen}, 32'd0);
        end
        run_checked("after_reset_read", 2, 1'b0, 32'h0000_0020, 32'h0, 32'hAAAA_AAAA, 1'b0);

        run_checked("l1_write", 1, 1'b1, 32'h0000_0004, 32'h0000_0044, 32'h0000_0000, 1'b0);
        run_checked("l1_read", 1, 1'b0, 32'h0000_0004, 32'h0, 32'h0000_0044, 1'b0);
        run_checked("l15_write", 15, 1'b1, 32'h0000_0004, 32'h0F0F_0015, 32'h0000_0000, 1'b0);
        run_checked("l15_read", 15, 1'b0, 32'h0000_0004, 32'h0, 32'h0F0F_0015, 1'b0);

`ifdef DMEM_PARITY_EN
        run_checked("par_write", 2, 1'b1, 32'h0000_0008, 32'h0000_0001, 32'hAAAA_AAAA, 1'b0);
        @(negedge clk);
        dut_l2.mem[2][0] = ~dut_l2.mem[2][0];
        run_checked("par_read", 2, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_0000, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
